// File: rtl/ibex_alu_issue.sv
// ibex_alu_issue
//   Issue/response wrapper around an external Ibex ALU. A request carrying
//   operator, three operands and a two-cycle flag is registered and driven
//   onto the ALU. The first cycle uses operands a/b. A second cycle, if
//   requested, uses a/c. The ALU outputs are captured into response
//   registers, which are held until the consumer takes them.
//
// Optional feature (macro IBEX_ALU_ISSUE_BYPASS_EN):
//   When defined, a new request may be accepted in the same cycle that the
//   pending response is consumed. This allows back-to-back issue.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i / req_ready_o     request handshake
//   req_op_i, req_a_i, req_b_i,   operator and operands (c = third operand)
//   req_c_i, req_two_cycle_i      two-cycle operation flag
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_result_o, rsp_cmp_o,      registered ALU result, comparison result
//   rsp_eq_o                      and equality result
//   alu_*_o                       operator/operands/first-cycle/imd values to the ALU
//   alu_*_i                       result, comparison, equality, imd write data/enables
module ibex_alu_issue #(
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [6:0]             req_op_i,
    input  logic [DATA_W-1:0]      req_a_i,
    input  logic [DATA_W-1:0]      req_b_i,
    input  logic [DATA_W-1:0]      req_c_i,
    input  logic                   req_two_cycle_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_result_o,
    output logic                   rsp_cmp_o,
    output logic                   rsp_eq_o,
    output logic [6:0]             alu_operator_o,
    output logic [DATA_W-1:0]      alu_operand_a_o,
    output logic [DATA_W-1:0]      alu_operand_b_o,
    output logic                   alu_instr_first_cycle_o,
    output logic                   alu_multdiv_sel_o,
    output logic [1:0][DATA_W-1:0] alu_imd_val_q_o,
    input  logic [DATA_W-1:0]      alu_result_i,
    input  logic                   alu_comparison_result_i,
    input  logic                   alu_is_equal_result_i,
    input  logic [1:0][DATA_W-1:0] alu_imd_val_d_i,
    input  logic [1:0]             alu_imd_val_we_i
);

    localparam logic [6:0] ALU_ADD = 7'd0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC1,
        EXEC2,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                accept;
    logic                capture;
    logic                imd_en;

    logic [6:0]          op_q;
    logic [DATA_W-1:0]   a_q, b_q, c_q;
    logic                two_q;

    logic [DATA_W-1:0]   result_q;
    logic                cmp_q, eq_q;
    logic [1:0][DATA_W-1:0] imd_q;

    assign accept            = req_valid_i & req_ready_o;
    assign alu_multdiv_sel_o = 1'b0;
    assign alu_imd_val_q_o   = imd_q;
    assign rsp_result_o      = result_q;
    assign rsp_cmp_o         = cmp_q;
    assign rsp_eq_o          = eq_q;

    always_comb begin
        state_d                 = state_q;
        req_ready_o             = 1'b0;
        rsp_valid_o             = 1'b0;
        alu_operator_o          = ALU_ADD;
        alu_operand_a_o         = '0;
        alu_operand_b_o         = '0;
        alu_instr_first_cycle_o = 1'b0;
        capture                 = 1'b0;
        imd_en                  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = EXEC1;
                end
            end
            EXEC1: begin
                alu_operator_o          = op_q;
                alu_operand_a_o         = a_q;
                alu_operand_b_o         = b_q;
                alu_instr_first_cycle_o = 1'b1;
                capture                 = 1'b1;
                imd_en                  = 1'b1;
                state_d                 = two_q ? EXEC2 : RESP;
            end
            EXEC2: begin
                // Second cycle swaps the third operand into the b slot.
                alu_operator_o  = op_q;
                alu_operand_a_o = a_q;
                alu_operand_b_o = c_q;
                capture         = 1'b1;
                imd_en          = 1'b1;
                state_d         = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
`ifdef IBEX_ALU_ISSUE_BYPASS_EN
                // The slot frees up exactly when the response leaves, so a
                // new request can be taken in the same cycle.
                req_ready_o = rsp_ready_i;
                if (rsp_ready_i) begin
                    state_d = req_valid_i ? EXEC1 : IDLE;
                end
`else
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            cmp_q    <= 1'b0;
            eq_q     <= 1'b0;
            imd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                result_q <= alu_result_i;
                cmp_q    <= alu_comparison_result_i;
                eq_q     <= alu_is_equal_result_i;
            end
            // A fresh operation must never see intermediate values left
            // behind by the previous one.
            if (accept) begin
                imd_q <= '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (imd_en && alu_imd_val_we_i[i]) begin
                        imd_q[i] <= alu_imd_val_d_i[i];
                    end
                end
            end
        end
    end

    // Request capture: operator and operands are data, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q  <= req_op_i;
            a_q   <= req_a_i;
            b_q   <= req_b_i;
            c_q   <= req_c_i;
            two_q <= req_two_cycle_i;
        end
    end

endmodule

// File: tb/tb_ibex_alu_issue.sv
module tb_ibex_alu_issue;

    localparam logic [6:0] OP_ADD = 7'd0;
    localparam logic [6:0] OP_SUB = 7'd1;
    localparam logic [6:0] OP_EQ  = 7'd2;
    localparam logic [31:0] IMD_KEY = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic        eq;
    } alu_t;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic        eq;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0, req_c = '0;
    logic        req_two = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_cmp, rsp_eq;
    logic [6:0]  alu_operator;
    logic [31:0] alu_operand_a, alu_operand_b;
    logic        alu_first, alu_multdiv_sel;
    logic [1:0][31:0] alu_imd_q, alu_imd_d;
    logic [1:0]  alu_imd_we;
    logic [31:0] alu_result;
    logic        alu_cmp, alu_eq;
    alu_t        stub_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit done = 0;
    exp_t expq[$];
    int   hs_log[$];

    ibex_alu_issue dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_op_i                (req_op),
        .req_a_i                 (req_a),
        .req_b_i                 (req_b),
        .req_c_i                 (req_c),
        .req_two_cycle_i         (req_two),
        .rsp_valid_o             (rsp_valid),
        .rsp_ready_i             (rsp_ready),
        .rsp_result_o            (rsp_result),
        .rsp_cmp_o               (rsp_cmp),
        .rsp_eq_o                (rsp_eq),
        .alu_operator_o          (alu_operator),
        .alu_operand_a_o         (alu_operand_a),
        .alu_operand_b_o         (alu_operand_b),
        .alu_instr_first_cycle_o (alu_first),
        .alu_multdiv_sel_o       (alu_multdiv_sel),
        .alu_imd_val_q_o         (alu_imd_q),
        .alu_result_i            (alu_result),
        .alu_comparison_result_i (alu_cmp),
        .alu_is_equal_result_i   (alu_eq),
        .alu_imd_val_d_i         (alu_imd_d),
        .alu_imd_val_we_i        (alu_imd_we)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic alu_t alu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_t r;
        case (op)
            OP_ADD:  r.res = a + b;
            OP_SUB:  r.res = a - b;
            OP_EQ:   r.res = {31'b0, a == b};
            default: r.res = a ^ b;
        endcase
        r.cmp = $signed(a) < $signed(b);
        r.eq  = (a == b);
        return r;
    endfunction

    // ALU stub: first cycle stores a^KEY in imd[0] and, when a is odd, the b
    // operand in imd[1]; the second cycle folds both imd values into its result.
    always_comb begin
        stub_r     = alu_fn(alu_operator, alu_operand_a, alu_operand_b);
        alu_result = stub_r.res;
        if (!alu_first) alu_result = stub_r.res ^ alu_imd_q[0] ^ alu_imd_q[1];
        alu_cmp      = stub_r.cmp;
        alu_eq       = stub_r.eq;
        alu_imd_d[0] = alu_operand_a ^ IMD_KEY;
        alu_imd_d[1] = alu_operand_b;
        alu_imd_we   = alu_first ? {alu_operand_a[0], 1'b1} : 2'b00;
    end

    // Reference: single-cycle ops are op(a,b); two-cycle ops are op(a,c)
    // combined with the intermediate values the first cycle produced.
    function automatic exp_t model(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic two, input int acc);
        exp_t e;
        alu_t r;
        r = alu_fn(op, a, two ? c : b);
        e.res = r.res;
        if (two) e.res = r.res ^ (a ^ IMD_KEY) ^ (a[0] ? b : 32'h0);
        e.cmp = r.cmp;
        e.eq  = r.eq;
        e.lat = acc + (two ? 3 : 2);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: checks every presented response against the scoreboard head.
    initial begin
        bit fresh = 1;
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst) begin
                fresh = 1;
            end else if (rsp_valid) begin
                chk("idle_alu_op", {57'b0, alu_operator}, {57'b0, OP_ADD});
                chk("idle_alu_ab", {alu_operand_a, alu_operand_b}, 64'h0);
`ifdef IBEX_ALU_ISSUE_BYPASS_EN
                chk("resp_req_ready", {63'b0, req_ready}, {63'b0, rsp_ready});
`else
                chk("resp_req_ready", {63'b0, req_ready}, 64'h0);
`endif
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response result=%0h at cycle %0d", rsp_result, cyc);
                end else begin
                    h = expq[0];
                    if (fresh) chk("latency", 64'(cyc), 64'(h.lat));
                    chk("rsp_result", {32'b0, rsp_result}, {32'b0, h.res});
                    chk("rsp_cmp_eq", {62'b0, rsp_cmp, rsp_eq}, {62'b0, h.cmp, h.eq});
                    if (rsp_ready) begin
                        void'(expq.pop_front());
                        hs_log.push_back(cyc);
                    end
                end
                fresh = rsp_ready;
            end else begin
                fresh = 1;
            end
        end
    end

    // Drives a request (valid stays high) until accepted; returns the
    // accept cycle. Entered and left at posedge+1.
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic two, output int acc);
        bit ok = 0;
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b; req_c = c; req_two = two;
        acc = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                expq.push_back(model(op, a, b, c, two, cyc));
                ok = 1;
            end
        end
        if (!ok) begin
            timeout("issue");
            req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            timeout("drain");
            expq.delete();
        end
    endtask

    initial begin
        int acc;
        int kf, kl;
        bit seen;
        logic [6:0]  op;
        logic [31:0] a, b, c;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {63'b0, req_ready}, 64'h1);
        chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'h0);
        chk("reset_imd", alu_imd_q, 64'h0);
        chk("reset_rsp", {31'b0, rsp_result, rsp_cmp, rsp_eq}, 64'h0);
        chk("reset_multdiv", {63'b0, alu_multdiv_sel}, 64'h0);
        @(posedge clk); #1;

        // ADD 10+5, consumer always ready; back to IDLE afterwards.
        rsp_ready = 1'b1;
        issue(OP_ADD, 32'd10, 32'd5, 32'd0, 1'b0, acc);
        req_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("add_then_idle", {63'b0, req_ready}, 64'h1);
        @(posedge clk); #1;

        // SUB 20-8 with the consumer stalling three cycles.
        rsp_ready = 1'b0;
        issue(OP_SUB, 32'd20, 32'd8, 32'd0, 1'b0, acc);
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) timeout("sub_valid");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain();
        @(posedge clk); #1;

        // Equality true then false.
        issue(OP_EQ, 32'd100, 32'd100, 32'd0, 1'b0, acc);
        issue(OP_EQ, 32'd100, 32'd99, 32'd0, 1'b0, acc);
        req_valid = 1'b0;
        drain();
        @(posedge clk); #1;

        // Two-cycle op: check the ALU-side view in both execute cycles.
        issue(OP_ADD, 32'd0, 32'd3, 32'h0000_0007, 1'b1, acc);
        req_valid = 1'b0;
        @(negedge clk);
        chk("exec1_first", {63'b0, alu_first}, 64'h1);
        chk("exec1_b", {32'b0, alu_operand_b}, 64'd3);
        @(negedge clk);
        chk("exec2_imd0", {32'b0, alu_imd_q[0]}, {32'b0, IMD_KEY});
        chk("exec2_imd1", {32'b0, alu_imd_q[1]}, 64'h0);
        chk("exec2_first", {63'b0, alu_first}, 64'h0);
        chk("exec2_b", {32'b0, alu_operand_b}, 64'd7);
        drain();
        @(posedge clk); #1;

        // Reset during EXEC2 abandons the operation (not on the scoreboard).
        req_valid = 1'b1; req_op = OP_SUB; req_a = 32'd9; req_b = 32'd1;
        req_c = 32'd2; req_two = 1'b1;
        @(negedge clk);
        chk("rst_test_ready", {63'b0, req_ready}, 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", {63'b0, rsp_valid}, 64'h0);
        chk("midrst_req_ready", {63'b0, req_ready}, 64'h1);
        chk("midrst_imd", alu_imd_q, 64'h0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;

        // Randomized traffic with a randomly stalling consumer.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    op = 7'($urandom_range(0, 2));
                    a  = $urandom;
                    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    c  = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    issue(op, a, b, c, 1'($urandom_range(0, 1)), acc);
                end
                req_valid = 1'b0;
                drain();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Four back-to-back ADDs with both sides always ready.
        hs_log.delete();
        for (int n = 0; n < 4; n++) begin
            issue(OP_ADD, 32'(n * 3), 32'(n + 1), 32'd0, 1'b0, acc);
        end
        req_valid = 1'b0;
        drain();
        chk("b2b_count", 64'(hs_log.size()), 64'd4);
        if (hs_log.size() == 4) begin
            kf = hs_log[0];
            kl = hs_log[3];
`ifdef IBEX_ALU_ISSUE_BYPASS_EN
            // Two cycles per response: four responses span 8 cycles.
            chk("b2b_span", 64'(kl - kf + 2), 64'd8);
`else
            // Three cycles per response: four responses span 12 cycles.
            chk("b2b_span", 64'(kl - kf + 3), 64'd12);
`endif
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
